// File: rtl/pc_pkg.sv
// Shared encodings for the PC/call sequencer and the instruction decoder.
//   OP_*    : 2-bit request opcodes carried on OP
//   IDLE,
//   RET_WAIT,
//   FAULT   : sequencer state encodings
package pc_pkg;

    localparam int unsigned OP_WIDTH = 2;

    localparam logic [OP_WIDTH-1:0] OP_NEXT = 2'b00;
    localparam logic [OP_WIDTH-1:0] OP_JMP  = 2'b01;
    localparam logic [OP_WIDTH-1:0] OP_CALL = 2'b10;
    localparam logic [OP_WIDTH-1:0] OP_RET  = 2'b11;

    localparam int unsigned ST_WIDTH = 2;

    localparam logic [ST_WIDTH-1:0] IDLE     = 2'd0;
    localparam logic [ST_WIDTH-1:0] RET_WAIT = 2'd1;
    localparam logic [ST_WIDTH-1:0] FAULT    = 2'd2;

endpackage

// File: rtl/pc_call_ctrl.sv
// Program counter and call/return sequencer in front of a return-address stack.
// Ports:
//   CLK, nRST        : clock, async active-low reset (shared with the stack)
//   OP_VALID, OP     : decoder request, accepted only in IDLE
//   TARGET           : JMP/CALL destination
//   PC               : registered program counter
//   BUSY             : high while waiting for popped return address
//   ERR_OVF, ERR_UNF : sticky stack overflow / underflow faults (PC frozen)
//   STK_DATA_IN, STK_CE, STK_nRW : push/pop command to the stack
//   STK_DATA_OUT, STK_FULL, STK_EMPTY : stack read data and status
module pc_call_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  OP_VALID,
    input  logic [1:0]            OP,
    input  logic [ADDR_WIDTH-1:0] TARGET,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  BUSY,
    output logic                  ERR_OVF,
    output logic                  ERR_UNF,
    output logic [ADDR_WIDTH-1:0] STK_DATA_IN,
    output logic                  STK_CE,
    output logic                  STK_nRW,
    input  logic [ADDR_WIDTH-1:0] STK_DATA_OUT,
    input  logic                  STK_FULL,
    input  logic                  STK_EMPTY
);

    logic [ST_WIDTH-1:0]   state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Wraps naturally at 2^ADDR_WIDTH.
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        STK_CE      = 1'b0;
        STK_nRW     = 1'b0;
        STK_DATA_IN = '0;

        case (state_q)
            IDLE: begin
                if (OP_VALID) begin
                    case (OP)
                        OP_NEXT: pc_d = pc_inc;
                        OP_JMP:  pc_d = TARGET;
                        OP_CALL: begin
                            if (!STK_FULL) begin
                                STK_CE      = 1'b1;
                                STK_nRW     = 1'b1;
                                STK_DATA_IN = pc_inc;
                                pc_d        = TARGET;
                            end else begin
                                ovf_d   = 1'b1;
                                state_d = FAULT;
                            end
                        end
                        default: begin  // OP_RET
                            if (!STK_EMPTY) begin
                                STK_CE  = 1'b1;
                                STK_nRW = 1'b0;
                                state_d = RET_WAIT;
                            end else begin
                                unf_d   = 1'b1;
                                state_d = FAULT;
                            end
                        end
                    endcase
                end
            end
            // Popped address appears on STK_DATA_OUT one cycle after the pop edge.
            RET_WAIT: begin
                pc_d    = STK_DATA_OUT;
                state_d = IDLE;
            end
            FAULT: begin
                // Terminal until reset.
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign PC      = pc_q;
    assign BUSY    = (state_q == RET_WAIT);
    assign ERR_OVF = ovf_q;
    assign ERR_UNF = unf_q;

endmodule

// File: tb/tb_pc_call_ctrl.sv
// Directed bench for pc_call_ctrl with a behavioural 3-deep return-address stack.
module tb_pc_call_ctrl;
    import pc_pkg::*;

    logic       CLK;
    logic       nRST;
    logic       OP_VALID;
    logic [1:0] OP;
    logic [7:0] TARGET;
    logic [7:0] PC;
    logic       BUSY;
    logic       ERR_OVF;
    logic       ERR_UNF;
    logic [7:0] STK_DATA_IN;
    logic       STK_CE;
    logic       STK_nRW;
    logic [7:0] STK_DATA_OUT;
    logic       STK_FULL;
    logic       STK_EMPTY;

    int n_checks;
    int n_pass;

    pc_call_ctrl #(
        .ADDR_WIDTH   (8),
        .RESET_VECTOR (8'h00)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .OP_VALID     (OP_VALID),
        .OP           (OP),
        .TARGET       (TARGET),
        .PC           (PC),
        .BUSY         (BUSY),
        .ERR_OVF      (ERR_OVF),
        .ERR_UNF      (ERR_UNF),
        .STK_DATA_IN  (STK_DATA_IN),
        .STK_CE       (STK_CE),
        .STK_nRW      (STK_nRW),
        .STK_DATA_OUT (STK_DATA_OUT),
        .STK_FULL     (STK_FULL),
        .STK_EMPTY    (STK_EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stack model, DEPTH=3: pop data registered, valid the cycle after the pop edge.
    logic [7:0] mem [0:2];
    logic [1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt          <= 2'd0;
            STK_DATA_OUT <= 8'h00;
        end else if (STK_CE) begin
            if (STK_nRW && cnt != 2'd3) begin
                mem[cnt] <= STK_DATA_IN;
                cnt      <= cnt + 2'd1;
            end else if (!STK_nRW && cnt != 2'd0) begin
                STK_DATA_OUT <= mem[cnt - 2'd1];
                cnt          <= cnt - 2'd1;
            end
        end
    end

    assign STK_FULL  = (cnt == 2'd3);
    assign STK_EMPTY = (cnt == 2'd0);

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] tgt);
        OP_VALID = v;
        OP       = op;
        TARGET   = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        OP_VALID = 1'b0;
        #3;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1'b0, OP_NEXT, 8'h00);
        #12;
        n_checks++; if (PC !== 8'h00) $display("FAIL reset_pc: got %h want 00", PC); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
        n_checks++;
        if ({ERR_OVF, ERR_UNF} !== 2'b00) $display("FAIL reset_err: got %b want 00", {ERR_OVF, ERR_UNF});
        else n_pass++;
        n_checks++;
        if ({STK_CE, STK_nRW, STK_DATA_IN} !== 10'h0)
            $display("FAIL reset_stk: got ce=%b nrw=%b din=%h want 0 0 00", STK_CE, STK_nRW, STK_DATA_IN);
        else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        n_checks++; if (PC !== 8'h00) $display("FAIL reset_release_pc: got %h want 00", PC); else n_pass++;
    endtask

    task automatic test_next_jmp();
        logic [7:0] exp_pc [0:5];
        exp_pc[0] = 8'h01; exp_pc[1] = 8'h02; exp_pc[2] = 8'h03;
        exp_pc[3] = 8'hFE; exp_pc[4] = 8'hFF; exp_pc[5] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) drive(1'b1, OP_JMP, 8'hFE);
            else drive(1'b1, OP_NEXT, 8'h55);
            n_checks++; if (STK_CE !== 1'b0) $display("FAIL next_jmp_ce[%0d]: got %b want 0", i, STK_CE); else n_pass++;
            tick();
            n_checks++;
            if (PC !== exp_pc[i]) $display("FAIL next_jmp_pc[%0d]: got %h want %h", i, PC, exp_pc[i]);
            else n_pass++;
        end
        drive(1'b0, OP_NEXT, 8'h00);
        tick();
        n_checks++; if (PC !== 8'h00) $display("FAIL idle_hold: got %h want 00", PC); else n_pass++;
    endtask

    task automatic test_call_ret();
        drive(1'b1, OP_JMP, 8'h10);
        tick();
        drive(1'b1, OP_CALL, 8'h40);
        n_checks++;
        if ({STK_CE, STK_nRW, STK_DATA_IN} !== {1'b1, 1'b1, 8'h11})
            $display("FAIL call_push: got ce=%b nrw=%b din=%h want 1 1 11", STK_CE, STK_nRW, STK_DATA_IN);
        else n_pass++;
        tick();
        n_checks++; if (PC !== 8'h40) $display("FAIL call_pc: got %h want 40", PC); else n_pass++;
        n_checks++; if (STK_EMPTY !== 1'b0) $display("FAIL call_stack: empty=%b want 0", STK_EMPTY); else n_pass++;
        drive(1'b1, OP_RET, 8'h00);
        n_checks++;
        if ({STK_CE, STK_nRW, STK_DATA_IN} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL ret_pop: got ce=%b nrw=%b din=%h want 1 0 00", STK_CE, STK_nRW, STK_DATA_IN);
        else n_pass++;
        tick();
        // Request during RET_WAIT must be ignored.
        drive(1'b1, OP_JMP, 8'h77);
        n_checks++;
        if ({BUSY, STK_CE} !== 2'b10) $display("FAIL ret_wait: got busy=%b ce=%b want 1 0", BUSY, STK_CE);
        else n_pass++;
        n_checks++; if (PC !== 8'h40) $display("FAIL ret_wait_pc: got %h want 40", PC); else n_pass++;
        tick();
        drive(1'b0, OP_NEXT, 8'h00);
        n_checks++; if (PC !== 8'h11) $display("FAIL ret_pc: got %h want 11", PC); else n_pass++;
        n_checks++;
        if ({BUSY, STK_EMPTY} !== 2'b01) $display("FAIL ret_done: got busy=%b empty=%b want 0 1", BUSY, STK_EMPTY);
        else n_pass++;
    endtask

    task automatic test_nested();
        logic [7:0] tgt [0:2];
        logic [7:0] ret [0:2];
        logic [7:0] pushed [0:2];
        tgt[0] = 8'h20; tgt[1] = 8'h30; tgt[2] = 8'h50;
        pushed[0] = 8'h06; pushed[1] = 8'h21; pushed[2] = 8'h31;
        ret[0] = 8'h31; ret[1] = 8'h21; ret[2] = 8'h06;
        drive(1'b1, OP_JMP, 8'h05);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_CALL, tgt[i]);
            n_checks++;
            if (STK_DATA_IN !== pushed[i]) $display("FAIL nest_push[%0d]: got %h want %h", i, STK_DATA_IN, pushed[i]);
            else n_pass++;
            tick();
        end
        n_checks++; if (PC !== 8'h50) $display("FAIL nest_pc: got %h want 50", PC); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_RET, 8'h00);
            tick();
            drive(1'b0, OP_NEXT, 8'h00);
            tick();
            n_checks++;
            if (PC !== ret[i]) $display("FAIL nest_ret[%0d]: got %h want %h", i, PC, ret[i]);
            else n_pass++;
        end
        n_checks++; if (STK_EMPTY !== 1'b1) $display("FAIL nest_empty: got %b want 1", STK_EMPTY); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] tgt [0:2];
        tgt[0] = 8'h20; tgt[1] = 8'h30; tgt[2] = 8'h50;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_CALL, tgt[i]);
            tick();
        end
        drive(1'b1, OP_CALL, 8'h60);
        n_checks++; if (STK_CE !== 1'b0) $display("FAIL ovf_ce: got %b want 0", STK_CE); else n_pass++;
        tick();
        n_checks++; if (PC !== 8'h50) $display("FAIL ovf_pc: got %h want 50", PC); else n_pass++;
        n_checks++; if (ERR_OVF !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ERR_OVF); else n_pass++;
        drive(1'b1, OP_JMP, 8'h99);
        tick();
        drive(1'b1, OP_RET, 8'h00);
        n_checks++;
        if ({STK_CE, BUSY} !== 2'b00) $display("FAIL fault_ret: got ce=%b busy=%b want 0 0", STK_CE, BUSY);
        else n_pass++;
        tick();
        n_checks++; if (PC !== 8'h50) $display("FAIL fault_frozen: got %h want 50", PC); else n_pass++;
        do_reset();
        n_checks++;
        if ({PC, ERR_OVF} !== {8'h00, 1'b0}) $display("FAIL ovf_clear: got pc=%h ovf=%b want 00 0", PC, ERR_OVF);
        else n_pass++;
    endtask

    task automatic test_underflow();
        drive(1'b1, OP_RET, 8'h00);
        n_checks++; if (STK_CE !== 1'b0) $display("FAIL unf_ce: got %b want 0", STK_CE); else n_pass++;
        tick();
        n_checks++;
        if ({ERR_UNF, ERR_OVF, PC} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL unf_flag: got unf=%b ovf=%b pc=%h want 1 0 00", ERR_UNF, ERR_OVF, PC);
        else n_pass++;
        drive(1'b1, OP_NEXT, 8'h00);
        tick();
        n_checks++; if (PC !== 8'h00) $display("FAIL unf_frozen: got %h want 00", PC); else n_pass++;
        do_reset();
        n_checks++; if (ERR_UNF !== 1'b0) $display("FAIL unf_clear: got %b want 0", ERR_UNF); else n_pass++;
    endtask

    task automatic test_reset_in_ret_wait();
        drive(1'b1, OP_CALL, 8'h40);
        tick();
        drive(1'b1, OP_RET, 8'h00);
        tick();
        drive(1'b0, OP_NEXT, 8'h00);
        n_checks++; if (BUSY !== 1'b1) $display("FAIL rw_busy: got %b want 1", BUSY); else n_pass++;
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if ({PC, BUSY, STK_CE} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL rw_abort: got pc=%h busy=%b ce=%b want 00 0 0", PC, BUSY, STK_CE);
        else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        tick();
        n_checks++; if (PC !== 8'h00) $display("FAIL rw_after: got %h want 00", PC); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        nRST     = 1'b0;
        OP_VALID = 1'b0;
        OP       = OP_NEXT;
        TARGET   = 8'h00;
        test_reset();
        test_next_jmp();
        test_call_ret();
        test_nested();
        test_overflow();
        test_underflow();
        test_reset_in_ret_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
